// File: rtl/stream_pkg.sv
// Shared stream definitions: skid state encoding and statistics counter width.
package stream_pkg;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  localparam int STAT_W = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = S_EMPTY,
    ST_ONE   = S_ONE,
    ST_TWO   = S_TWO
  } skid_state_t;

endpackage

// File: rtl/fifo_stream_out.sv
// fifo_stream_out: pops a show-ahead FIFO into a registered valid/ready stream
// through a 2-entry skid (output register + one skid register).
// Optional macro FIFO_STREAM_OUT_STATS_EN adds beat/stall counters.
module fifo_stream_out
  import stream_pkg::*;
#(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      fifo_rdata,
  input  logic              fifo_empty,
  output logic              fifo_re,
  input  logic              flush,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef FIFO_STREAM_OUT_STATS_EN
  output logic [STAT_W-1:0] stat_beats,
  output logic [STAT_W-1:0] stat_stalls,
`endif
  output logic [1:0]        occ
);

  skid_state_t state, state_next;
  logic [W-1:0] skid_q, skid_d, out_d;
  logic xfer;

  assign xfer    = out_valid & out_ready;
  assign fifo_re = ~fifo_empty & ~flush & ((state != ST_TWO) | out_ready);

  // Next state and data steering; flush overrides every other event.
  always_comb begin
    state_next = state;
    out_d      = out_data;
    skid_d     = skid_q;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (fifo_re) begin
            out_d      = fifo_rdata;
            state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          if (fifo_re && xfer) begin
            out_d = fifo_rdata;
          end else if (fifo_re) begin
            skid_d     = fifo_rdata;
            state_next = ST_TWO;
          end else if (xfer) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (xfer) begin
            out_d = skid_q;
            if (fifo_re) begin
              skid_d = fifo_rdata;
            end else begin
              state_next = ST_ONE;
            end
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // State, data registers and registered valid/occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_data  <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      occ       <= 2'd0;
    end else begin
      state     <= state_next;
      out_data  <= out_d;
      skid_q    <= skid_d;
      out_valid <= (state_next != ST_EMPTY);
      case (state_next)
        ST_ONE:  occ <= 2'd1;
        ST_TWO:  occ <= 2'd2;
        default: occ <= 2'd0;
      endcase
    end
  end

`ifdef FIFO_STREAM_OUT_STATS_EN
  // Accepted-beat and stall-cycle counters, wrapping, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else if (flush) begin
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else begin
      if (xfer) begin
        stat_beats <= stat_beats + 1'b1;
      end
      if (out_valid && !out_ready) begin
        stat_stalls <= stat_stalls + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: behavioural show-ahead FIFO (depth 32) plus a
// queue-based reference of words popped but not yet accepted downstream.
module tb_fifo_stream_out;

  localparam int W = 32;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [W-1:0] fifo_rdata = '0;
  logic fifo_empty = 1'b1;
  logic fifo_re;
  logic flush = 1'b0;
  logic [W-1:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [1:0] occ;
`ifdef FIFO_STREAM_OUT_STATS_EN
  logic [31:0] stat_beats, stat_stalls;
`endif

  fifo_stream_out #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef FIFO_STREAM_OUT_STATS_EN
    .stat_beats (stat_beats),
    .stat_stalls(stat_stalls),
`endif
    .occ        (occ)
  );

  always #5 clk = ~clk;

  logic wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] seen_q[$];
  int checks = 0;
  int passes = 0;
  int fails = 0;
  int total_xfers = 0;
  int unsigned ref_beats = 0;
  int unsigned ref_stalls = 0;

  task automatic check_output(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic wr, input logic [W-1:0] data,
                                input logic ready, input logic fl);
    wr_en     = wr;
    wr_data   = data;
    out_ready = ready;
    flush     = fl;
  endtask

  // One clock: check DUT against the model at negedge, then advance FIFO and model.
  task automatic run_cycle();
    logic pop, xfer, stall;
    logic [W-1:0] rd;
    int n;
    @(negedge clk);
    n = exp_q.size();
    check_output("out_valid", W'(out_valid), W'(n != 0));
    check_output("occ", W'(occ), W'(n));
    if (n != 0) check_output("out_data", out_data, exp_q[0]);
    check_output("fifo_re", W'(fifo_re),
                 W'(rst_n && fifo_q.size() != 0 && !flush && (n < 2 || out_ready)));
`ifdef FIFO_STREAM_OUT_STATS_EN
    check_output("stat_beats", stat_beats, ref_beats);
    check_output("stat_stalls", stat_stalls, ref_stalls);
`endif
    pop   = rst_n && fifo_re && fifo_q.size() != 0;
    rd    = pop ? fifo_q[0] : '0;
    xfer  = out_valid && out_ready;
    stall = out_valid && !out_ready;
    @(posedge clk);
    if (xfer && exp_q.size() != 0) begin
      seen_q.push_back(exp_q.pop_front());
      total_xfers++;
    end
    if (flush) begin
      exp_q.delete();
      ref_beats  = 0;
      ref_stalls = 0;
    end else begin
      ref_beats  += xfer ? 1 : 0;
      ref_stalls += stall ? 1 : 0;
      if (pop) exp_q.push_back(rd);
    end
    if (pop) void'(fifo_q.pop_front());
    if (wr_en && rst_n) fifo_q.push_back(wr_data);
    fifo_empty <= (fifo_q.size() == 0);
    fifo_rdata <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #1;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic do_reset();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    ref_beats  = 0;
    ref_stalls = 0;
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    #1;
    check_output("rst_out_valid", W'(out_valid), '0);
    check_output("rst_occ", W'(occ), '0);
    check_output("rst_out_data", out_data, '0);
    check_output("rst_fifo_re", W'(fifo_re), '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int s0, run, maxrun, written, cyc;
    #2;
    do_reset();

    // Test 1: single word latency.
    check_output("t1_re_idle", W'(fifo_re), '0);
    apply_stimulus(1'b1, 32'hA5, 1'b0, 1'b0);
    run_cycle();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("t1_re_next", W'(fifo_re), 1);
    run_cycle();
    check_output("t1_valid", W'(out_valid), 1);
    check_output("t1_data", out_data, 32'hA5);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    repeat (3) run_cycle();

    // Test 2: 32 words, always ready, no gaps once valid rises.
    run = 0;
    maxrun = 0;
    s0 = total_xfers;
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1'b1, W'(i), 1'b1, 1'b0);
      run_cycle();
      run = out_valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      run = out_valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    check_output("t2_run", W'(maxrun), 32);
    check_output("t2_count", W'(total_xfers - s0), 32);

    // Test 3: backpressure fills skid, then drains in order.
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      apply_stimulus(1'b1, W'(i), 1'b0, 1'b0);
      run_cycle();
    end
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    repeat (5) run_cycle();
    check_output("t3_occ", W'(occ), 2);
    check_output("t3_data", out_data, 1);
    check_output("t3_re", W'(fifo_re), 0);
    s0 = seen_q.size();
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    repeat (3) run_cycle();
    check_output("t3_count", W'(seen_q.size() - s0), 3);
    if (seen_q.size() - s0 == 3) begin
      check_output("t3_w0", seen_q[s0], 1);
      check_output("t3_w1", seen_q[s0+1], 2);
      check_output("t3_w2", seen_q[s0+2], 3);
    end
    repeat (2) run_cycle();

    // Test 4: random traffic, 1000 words.
    s0 = total_xfers;
    written = 0;
    cyc = 0;
    while ((written < 1000 || exp_q.size() != 0 || fifo_q.size() != 0) && cyc < 20000) begin
      if (written < 1000 && fifo_q.size() < DEPTH && $urandom_range(1, 0) == 1) begin
        apply_stimulus(1'b1, $urandom, $urandom_range(1, 0) == 1, 1'b0);
        written++;
      end else begin
        apply_stimulus(1'b0, '0, $urandom_range(1, 0) == 1, 1'b0);
      end
      run_cycle();
      cyc++;
    end
    check_output("t4_bound", W'(cyc < 20000), 1);
    check_output("t4_count", W'(total_xfers - s0), 1000);

    // Test 5: flush with two words held; the FIFO word behind them survives.
    for (int i = 10; i <= 12; i++) begin
      apply_stimulus(1'b1, W'(i), 1'b0, 1'b0);
      run_cycle();
    end
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    run_cycle();
    check_output("t5_occ_pre", W'(occ), 2);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    run_cycle();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("t5_valid", W'(out_valid), 0);
    check_output("t5_occ", W'(occ), 0);
    s0 = seen_q.size();
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    repeat (4) run_cycle();
    check_output("t5_count", W'(seen_q.size() - s0), 1);
    if (seen_q.size() - s0 == 1) check_output("t5_word", seen_q[s0], 12);

    // Test 6: asynchronous reset with skid full, then recovery.
    for (int i = 20; i <= 22; i++) begin
      apply_stimulus(1'b1, W'(i), 1'b0, 1'b0);
      run_cycle();
    end
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    run_cycle();
    check_output("t6_occ_pre", W'(occ), 2);
    do_reset();
    s0 = seen_q.size();
    apply_stimulus(1'b1, 32'h77, 1'b1, 1'b0);
    run_cycle();
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    repeat (3) run_cycle();
    check_output("t6_count", W'(seen_q.size() - s0), 1);
    if (seen_q.size() - s0 == 1) check_output("t6_word", seen_q[s0], 32'h77);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
